flit_packetizer: RTL and testbench

Transmit-side network-interface block that turns a core-side packet request (destination address, data-flit count) plus a stream of payload words into a serial flit stream on the router injection link. It emits one head flit carrying the address and length, then the body flits, and marks the last one as tail. It is the sending end of the flit format whose receiving end counts flits down and latches the head address.

---
 rtl/noc_pkg.sv | 20 ++
 rtl/flit_out_stage.sv | 41 ++++
 rtl/flit_packetizer.sv | 87 ++++++++
 tb/tb_flit_packetizer.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// noc_pkg: shared types and head-flit field layout for the injection-side blocks
// Contents: tx_state_t (IDLE/BODY) and the bit positions of the head-flit fields.
package noc_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BODY = 1'b1
    } tx_state_t;

    // Head flit layout: length in the low ADD_WIDTH bits, 8-bit address just above it.
    localparam int ADDR_WIDTH    = 8;
    localparam int HEAD_LEN_LSB  = 0;
    localparam int DEF_ADD_WIDTH = 8;
    localparam int HEAD_ADDR_LSB = DEF_ADD_WIDTH;

    function automatic int head_addr_lsb(input int add_width);
        return HEAD_LEN_LSB + add_width;
    endfunction

endpackage

// File: rtl/flit_out_stage.sv
// flit_out_stage: single-entry registered output slot for a flit link
// Ports: load/load_flit/load_head/load_tail write the slot (only when free);
//        link_ready is downstream acceptance; free = slot empty or draining;
//        valid/flit/head/tail are the registered link outputs.
module flit_out_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_flit,
    input  logic             load_head,
    input  logic             load_tail,
    input  logic             link_ready,
    output logic             free,
    output logic             valid,
    output logic [WIDTH-1:0] flit,
    output logic             head,
    output logic             tail
);

    assign free = !valid || link_ready;

    // Contents are only rewritten on load, so a stalled flit stays stable.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid <= 1'b0;
            flit  <= '0;
            head  <= 1'b0;
            tail  <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            flit  <= load_flit;
            head  <= load_head;
            tail  <= load_tail;
        end else if (link_ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/flit_packetizer.sv
// flit_packetizer: turns a packet request plus payload words into head/body/tail flits
// Ports: pkt_* request handshake (address, body-flit count N); data_* payload handshake;
//        flit_* registered link outputs with link_ready_i back-pressure; busy_o while a
//        packet is in progress or a flit is still on the link.
module flit_packetizer
    import noc_pkg::*;
#(
    parameter int ADD_WIDTH  = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pkt_valid_i,
    input  logic [ADDR_WIDTH-1:0] pkt_address_i,
    input  logic [ADD_WIDTH-1:0]  pkt_length_i,
    output logic                  pkt_ready_o,
    input  logic                  data_valid_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  data_ready_o,
    output logic                  flit_valid_o,
    output logic [DATA_WIDTH-1:0] flit_o,
    output logic                  flit_head_o,
    output logic                  flit_tail_o,
    input  logic                  link_ready_i,
    output logic                  busy_o
);

    localparam int ADDR_LSB = head_addr_lsb(ADD_WIDTH);

    tx_state_t             state_q;
    logic [ADD_WIDTH-1:0]  remaining_q;
    logic                  free;
    logic                  pkt_fire;
    logic                  data_fire;
    logic                  load;
    logic                  load_tail;
    logic [DATA_WIDTH-1:0] head_flit;
    logic [DATA_WIDTH-1:0] load_flit;

    assign pkt_ready_o  = (state_q == IDLE) && free;
    assign data_ready_o = (state_q == BODY) && free;
    assign pkt_fire     = pkt_valid_i && pkt_ready_o;
    assign data_fire    = data_valid_i && data_ready_o;
    assign load         = pkt_fire || data_fire;
    assign busy_o       = (state_q == BODY) || flit_valid_o;

    always_comb begin
        head_flit = '0;
        head_flit[HEAD_LEN_LSB +: ADD_WIDTH] = pkt_length_i;
        head_flit[ADDR_LSB +: ADDR_WIDTH]    = pkt_address_i;
    end

    // A zero-length request is a single flit that is both head and tail.
    assign load_flit = pkt_fire ? head_flit : data_i;
    assign load_tail = pkt_fire ? (pkt_length_i == '0) : (remaining_q == ADD_WIDTH'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            remaining_q <= '0;
        end else if (pkt_fire) begin
            state_q     <= (pkt_length_i == '0) ? IDLE : BODY;
            remaining_q <= pkt_length_i;
        end else if (data_fire) begin
            state_q     <= (remaining_q == ADD_WIDTH'(1)) ? IDLE : BODY;
            remaining_q <= remaining_q - ADD_WIDTH'(1);
        end
    end

    flit_out_stage #(
        .WIDTH(DATA_WIDTH)
    ) u_out (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .load_flit (load_flit),
        .load_head (pkt_fire),
        .load_tail (load_tail),
        .link_ready(link_ready_i),
        .free      (free),
        .valid     (flit_valid_o),
        .flit      (flit_o),
        .head      (flit_head_o),
        .tail      (flit_tail_o)
    );

endmodule

// File: tb/tb_flit_packetizer.sv
// tb_flit_packetizer: directed stimulus, packet-level flit model and per-cycle link checker
module tb_flit_packetizer;

    localparam int AW = 8;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          pkt_valid = 1'b0;
    logic [7:0]    pkt_address = '0;
    logic [AW-1:0] pkt_length = '0;
    logic          pkt_ready;
    logic          data_valid = 1'b0;
    logic [DW-1:0] data = '0;
    logic          data_ready;
    logic          flit_valid;
    logic [DW-1:0] flit;
    logic          flit_head;
    logic          flit_tail;
    logic          link_ready = 1'b1;
    logic          busy;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    logic [DW+1:0] exp_q[$];
    int xfer_q[$];
    logic abort = 1'b0;
    logic mon_en = 1'b0;
    logic [DW-1:0] words[8];
    logic [DW-1:0] lit_d[4];
    logic lit_h[4];
    logic lit_t[4];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    flit_packetizer #(.ADD_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .reset(reset),
        .pkt_valid_i(pkt_valid), .pkt_address_i(pkt_address), .pkt_length_i(pkt_length),
        .pkt_ready_o(pkt_ready),
        .data_valid_i(data_valid), .data_i(data), .data_ready_o(data_ready),
        .flit_valid_o(flit_valid), .flit_o(flit), .flit_head_o(flit_head), .flit_tail_o(flit_tail),
        .link_ready_i(link_ready), .busy_o(busy)
    );

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chkb(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b, expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: timed out waiting (cycle %0d)", name, cyc);
    endtask

    task automatic smp;
        @(negedge clk);
        #3;
    endtask

    task automatic slot;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input bit is_pkt);
        for (int k = 0; k < 100; k++) begin
            smp;
            if (abort) return;
            if (is_pkt ? pkt_ready : data_ready) begin
                slot;
                return;
            end
        end
        timeout(is_pkt ? "pkt_handshake" : "data_handshake");
    endtask

    // Model: a packet is its head flit ({address, N}) followed by its N words, last one tail.
    task automatic send_pkt(input logic [7:0] a, input int n);
        logic [DW-1:0] h;
        h = (DW'(a) << AW) | DW'(n);
        exp_q.push_back({n == 0, 1'b1, h});
        for (int i = 0; i < n; i++) exp_q.push_back({i == n - 1, 1'b0, words[i]});
        pkt_valid = 1'b1;
        pkt_address = a;
        pkt_length = AW'(n);
        wait_ready(1'b1);
        pkt_valid = 1'b0;
        for (int i = 0; i < n && !abort; i++) begin
            data_valid = 1'b1;
            data = words[i];
            wait_ready(1'b0);
        end
        data_valid = 1'b0;
    endtask

    task automatic watch(input int n, input bit nodr);
        int ok;
        ok = 0;
        for (int k = 0; k < 100; k++) begin
            smp;
            if (pkt_valid && pkt_ready) begin
                ok = 1;
                break;
            end
        end
        if (ok == 0) begin
            timeout("watch_accept");
            return;
        end
        if (nodr) chkb("no_data_ready", data_ready, 1'b0);
        for (int i = 0; i < n; i++) begin
            smp;
            chkb("lit_valid", flit_valid, 1'b1);
            chk("lit_flit", flit, lit_d[i]);
            chkb("lit_head", flit_head, lit_h[i]);
            chkb("lit_tail", flit_tail, lit_t[i]);
            if (nodr) chkb("no_data_ready", data_ready, 1'b0);
        end
        if (nodr) repeat (2) begin
            smp;
            chkb("no_data_ready", data_ready, 1'b0);
        end
    endtask

    task automatic drain;
        for (int k = 0; k < 200; k++) begin
            smp;
            if (exp_q.size() == 0 && !flit_valid) return;
        end
        timeout("drain");
    endtask

    // Link checker: every transfer must be the next modelled flit; a stalled flit must hold.
    initial begin
        logic pv;
        logic plr;
        logic [DW-1:0] pf;
        logic [DW+1:0] e;
        pv = 1'b0;
        plr = 1'b1;
        pf = '0;
        forever begin
            smp;
            if (reset || !mon_en) begin
                pv = 1'b0;
                continue;
            end
            if (pv && !plr) begin
                chkb("hold_valid", flit_valid, 1'b1);
                chk("hold_flit", flit, pf);
            end
            if (flit_valid && link_ready) begin
                if (exp_q.size() == 0) begin
                    timeout("unexpected_flit");
                end else begin
                    e = exp_q.pop_front();
                    chk("flit_data", flit, e[DW-1:0]);
                    chkb("flit_head", flit_head, e[DW]);
                    chkb("flit_tail", flit_tail, e[DW+1]);
                    xfer_q.push_back(cyc);
                end
            end
            pv = flit_valid;
            plr = link_ready;
            pf = flit;
        end
    end

    initial begin
        int n0;
        int ok;
        repeat (3) @(posedge clk);
        smp;
        chkb("rst_valid", flit_valid, 1'b0);
        chk("rst_flit", flit, '0);
        chkb("rst_head", flit_head, 1'b0);
        chkb("rst_tail", flit_tail, 1'b0);
        chkb("rst_pkt_ready", pkt_ready, 1'b1);
        chkb("rst_data_ready", data_ready, 1'b0);
        chkb("rst_busy", busy, 1'b0);
        slot;
        reset = 1'b0;
        mon_en = 1'b1;

        // N=3 to address 0x5A, link always ready
        words[0] = 32'h11; words[1] = 32'h22; words[2] = 32'h33;
        lit_d[0] = 32'h5A03; lit_h[0] = 1'b1; lit_t[0] = 1'b0;
        lit_d[1] = 32'h11;   lit_h[1] = 1'b0; lit_t[1] = 1'b0;
        lit_d[2] = 32'h22;   lit_h[2] = 1'b0; lit_t[2] = 1'b0;
        lit_d[3] = 32'h33;   lit_h[3] = 1'b0; lit_t[3] = 1'b1;
        fork
            send_pkt(8'h5A, 3);
            watch(4, 1'b0);
        join
        drain;
        slot;

        // single-flit packet
        lit_d[0] = 32'h0700; lit_h[0] = 1'b1; lit_t[0] = 1'b1;
        fork
            send_pkt(8'h07, 0);
            watch(1, 1'b1);
        join
        drain;
        slot;

        // three-cycle stall while the first body flit sits on the link
        words[0] = 32'hAB; words[1] = 32'hCD;
        fork
            send_pkt(8'h10, 2);
            begin
                ok = 0;
                for (int k = 0; k < 100; k++) begin
                    @(negedge clk);
                    #1;
                    if (flit_valid && flit == 32'hAB) begin
                        ok = 1;
                        break;
                    end
                end
                if (ok == 0) timeout("stall_find");
                link_ready = 1'b0;
                repeat (3) begin
                    #2;
                    chk("stall_flit", flit, 32'hAB);
                    chkb("stall_valid", flit_valid, 1'b1);
                    chkb("stall_data_ready", data_ready, 1'b0);
                    @(negedge clk);
                    #1;
                end
                link_ready = 1'b1;
            end
        join
        drain;
        slot;

        // back-to-back single-body packets: four flits in four cycles
        n0 = xfer_q.size();
        words[0] = 32'h44;
        send_pkt(8'h21, 1);
        words[0] = 32'h55;
        send_pkt(8'h22, 1);
        drain;
        chk("b2b_count", DW'(xfer_q.size() - n0), 32'd4);
        if (xfer_q.size() - n0 == 4) chk("b2b_span", DW'(xfer_q[n0+3] - xfer_q[n0]), 32'd3);
        slot;

        // payload offered before any request is held off
        data_valid = 1'b1;
        data = 32'hFF;
        repeat (3) begin
            smp;
            chkb("idle_data_ready", data_ready, 1'b0);
            chkb("idle_no_flit", flit_valid, 1'b0);
        end
        slot;
        words[0] = 32'hFF;
        send_pkt(8'h33, 1);
        drain;
        slot;

        // reset during the second body flit of an N=4 packet
        words[0] = 32'hA1; words[1] = 32'hA2; words[2] = 32'hA3; words[3] = 32'hA4;
        fork
            send_pkt(8'h44, 4);
            begin
                ok = 0;
                for (int k = 0; k < 100; k++) begin
                    @(negedge clk);
                    #1;
                    if (flit_valid && flit == 32'hA2) begin
                        ok = 1;
                        break;
                    end
                end
                if (ok == 0) timeout("reset_find");
                reset = 1'b1;
                #1;
                chkb("arst_valid", flit_valid, 1'b0);
                chkb("arst_busy", busy, 1'b0);
                chk("arst_flit", flit, '0);
                chkb("arst_tail", flit_tail, 1'b0);
                abort = 1'b1;
            end
        join
        exp_q.delete();
        slot;
        slot;
        reset = 1'b0;
        abort = 1'b0;
        words[0] = 32'h99;
        lit_d[0] = 32'h3C01; lit_h[0] = 1'b1; lit_t[0] = 1'b0;
        lit_d[1] = 32'h99;   lit_h[1] = 1'b0; lit_t[1] = 1'b1;
        fork
            send_pkt(8'h3C, 1);
            watch(2, 1'b0);
        join
        drain;
        chk("queue_empty", DW'(exp_q.size()), '0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
